// File: rtl/fifo_axis_rr_arb.sv
// fifo_axis_rr_arb: round-robin burst arbiter that drains C_NUM_SRC standard-mode
// FIFOs (1-cycle read latency) into one AXI-stream master with a 2-entry output queue.
// Optional build macro FIFO_ARB_WORD_SWAP_EN reverses the 32-bit lanes of every
// captured word; without it m_tdata is bit-exact src_q. Timing is identical either way.
module fifo_axis_rr_arb #(
  parameter int C_DATA_W  = 128,
  parameter int C_NUM_SRC = 4,
  parameter int C_ID_W    = 2,
  parameter int C_BURST   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [C_NUM_SRC-1:0]          src_empty,
  input  logic [C_NUM_SRC*C_DATA_W-1:0] src_q,
  output logic [C_NUM_SRC-1:0]          src_rd_en,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [C_DATA_W-1:0]           m_tdata,
  output logic [C_ID_W-1:0]             m_tid,
  output logic                          m_tlast,
  output logic [C_NUM_SRC-1:0]          grant,
  output logic                          busy
);

  localparam int         IDX_W      = (C_NUM_SRC > 1) ? $clog2(C_NUM_SRC) : 1;
  localparam logic [8:0] BURST_MAX  = 9'(C_BURST);
  localparam logic [8:0] BURST_LAST = 9'(C_BURST - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [IDX_W-1:0]     ptr_r;
  logic [IDX_W-1:0]     gidx_r;
  logic [IDX_W-1:0]     infl_src_r;
  logic [IDX_W-1:0]     arb_idx_s;
  logic [IDX_W-1:0]     cand_s;
  logic [C_NUM_SRC-1:0] grant_r;
  logic [8:0]           rd_cnt_r;
  logic                 infl_r;
  logic                 infl_last_r;
  logic [1:0]           occ_r;
  logic [C_DATA_W-1:0]  q_data_r [2];
  logic [C_ID_W-1:0]    q_tid_r [2];
  logic [1:0]           q_last_r;
  logic                 arb_hit_s;
  logic                 rd_s;
  logic                 rd_last_s;
  logic                 pop_s;
  logic                 wr_idx_s;
  logic [C_DATA_W-1:0]  src_word_s [C_NUM_SRC];
  logic [C_DATA_W-1:0]  cap_word_s;

`ifdef FIFO_ARB_WORD_SWAP_EN
  // Reverse the order of the 32-bit lanes of a word.
  function automatic logic [C_DATA_W-1:0] lane_swap(input logic [C_DATA_W-1:0] d);
    logic [C_DATA_W-1:0] r;
    r = '0;
    for (int k = 0; k < C_DATA_W / 32; k++) begin
      r[32*(C_DATA_W/32-1-k) +: 32] = d[32*k +: 32];
    end
    return r;
  endfunction
`endif

  for (genvar gi = 0; gi < C_NUM_SRC; gi++) begin : g_slice
    assign src_word_s[gi] = src_q[gi*C_DATA_W +: C_DATA_W];
  end

  // The word returned by last cycle's read belongs to the source granted at read time.
`ifdef FIFO_ARB_WORD_SWAP_EN
  assign cap_word_s = lane_swap(src_word_s[infl_src_r]);
`else
  assign cap_word_s = src_word_s[infl_src_r];
`endif

  assign m_tvalid = (occ_r != 2'd0);
  assign m_tdata  = q_data_r[0];
  assign m_tid    = q_tid_r[0];
  assign m_tlast  = q_last_r[0];
  assign grant    = grant_r;
  assign pop_s    = m_tvalid && m_tready;
  // A word still returning from the FIFO counts as queued so busy never dips mid-flush.
  assign busy     = (state_r != IDLE) || m_tvalid || infl_r;

  // Round-robin scan: first non-empty source starting just after the last winner.
  always_comb begin
    arb_hit_s = 1'b0;
    arb_idx_s = '0;
    cand_s    = '0;
    for (int k = 1; k <= C_NUM_SRC; k++) begin
      cand_s = IDX_W'((int'(ptr_r) + k) % C_NUM_SRC);
      if (!arb_hit_s && !src_empty[cand_s]) begin
        arb_hit_s = 1'b1;
        arb_idx_s = cand_s;
      end else begin
        arb_hit_s = arb_hit_s;
      end
    end
  end

  // FSM next state and read strobe; a read needs a free slot in queue+pipeline or a pop.
  always_comb begin
    state_nxt_s = state_r;
    rd_s        = 1'b0;
    rd_last_s   = 1'b0;
    src_rd_en   = '0;
    case (state_r)
      IDLE: begin
        if (arb_hit_s) begin
          state_nxt_s = XFER;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      XFER: begin
        rd_s = !src_empty[gidx_r] && (rd_cnt_r < BURST_MAX) &&
               ((({1'b0, occ_r} + {2'b00, infl_r}) < 3'd2) || pop_s);
        rd_last_s = rd_s && (rd_cnt_r == BURST_LAST);
        if (rd_s) begin
          src_rd_en[gidx_r] = 1'b1;
        end else begin
          src_rd_en = '0;
        end
        if (rd_last_s || (src_empty[gidx_r] && !rd_s)) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = XFER;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Queue write slot: after a pop the tail moves down one (occ 2 -> slot 1, occ 1 -> slot 0).
  always_comb begin
    if (pop_s) begin
      wr_idx_s = occ_r[1];
    end else begin
      wr_idx_s = occ_r[0];
    end
  end

  // State, grant, burst counter and read-pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      ptr_r       <= IDX_W'(C_NUM_SRC - 1);
      gidx_r      <= '0;
      grant_r     <= '0;
      rd_cnt_r    <= 9'd0;
      infl_r      <= 1'b0;
      infl_src_r  <= '0;
      infl_last_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        IDLE: begin
          if (arb_hit_s) begin
            grant_r  <= {{(C_NUM_SRC-1){1'b0}}, 1'b1} << arb_idx_s;
            ptr_r    <= arb_idx_s;
            gidx_r   <= arb_idx_s;
            rd_cnt_r <= 9'd0;
          end else begin
            grant_r <= '0;
          end
        end
        XFER: begin
          if (rd_s) begin
            rd_cnt_r <= rd_cnt_r + 9'd1;
          end
          if (state_nxt_s == IDLE) begin
            grant_r <= '0;
          end
        end
        default: grant_r <= '0;
      endcase
      infl_r      <= rd_s;
      infl_src_r  <= gidx_r;
      infl_last_r <= rd_last_s;
    end
  end

  // Two-entry output queue: slot 0 is the head; capture and pop may coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_r       <= 2'd0;
      q_data_r[0] <= '0;
      q_data_r[1] <= '0;
      q_tid_r[0]  <= '0;
      q_tid_r[1]  <= '0;
      q_last_r    <= 2'b00;
    end else begin
      if (pop_s) begin
        q_data_r[0] <= q_data_r[1];
        q_tid_r[0]  <= q_tid_r[1];
        q_last_r[0] <= q_last_r[1];
      end
      if (infl_r) begin
        q_data_r[wr_idx_s] <= cap_word_s;
        q_tid_r[wr_idx_s]  <= C_ID_W'(infl_src_r);
        q_last_r[wr_idx_s] <= infl_last_r;
      end
      case ({infl_r, pop_s})
        2'b10:   occ_r <= occ_r + 2'd1;
        2'b01:   occ_r <= occ_r - 2'd1;
        default: occ_r <= occ_r;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_axis_rr_arb.sv
// Self-checking bench for fifo_axis_rr_arb: emulated source FIFOs, a burst-level
// reference model feeding a scoreboard, and an independent output monitor.
module tb_fifo_axis_rr_arb;

  localparam int DW = 128;
  localparam int NS = 4;
  localparam int IW = 2;
  localparam int BL = 16;

  logic             clk;
  logic             rst;
  logic [NS-1:0]    src_empty;
  logic [NS*DW-1:0] src_q;
  logic [NS-1:0]    src_rd_en;
  logic             m_tvalid;
  logic             m_tready;
  logic [DW-1:0]    m_tdata;
  logic [IW-1:0]    m_tid;
  logic             m_tlast;
  logic [NS-1:0]    grant;
  logic             busy;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] tid;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] fq [NS][$];
  int            hs_cyc[$];
  int            hs_tid[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            hs_cnt = 0;
  int            model_ptr = NS - 1;
  int            rmode = 0;
  int            outstanding = 0;
  logic [DW-1:0] last_data = '0;

  fifo_axis_rr_arb #(
    .C_DATA_W (DW),
    .C_NUM_SRC(NS),
    .C_ID_W   (IW),
    .C_BURST  (BL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .src_empty(src_empty),
    .src_q    (src_q),
    .src_rd_en(src_rd_en),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tid    (m_tid),
    .m_tlast  (m_tlast),
    .grant    (grant),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] tb_swap(input logic [DW-1:0] d);
    logic [DW-1:0] r;
`ifdef FIFO_ARB_WORD_SWAP_EN
    for (int k = 0; k < DW / 32; k++) r[32*(DW/32-1-k) +: 32] = d[32*k +: 32];
`else
    r = d;
`endif
    return r;
  endfunction

  task automatic load_src(input int s, input int n);
    logic [DW-1:0] w;
    for (int j = 0; j < n; j++) begin
      for (int l = 0; l < DW / 32; l++) w[32*l +: 32] = $urandom;
      fq[s].push_back(w);
    end
  endtask

  // Reference: with all FIFOs loaded up front, the stream is fixed by round-robin
  // order and min(BL, remaining) words per turn; tlast only on a full burst.
  task automatic model_build();
    int pos [NS];
    int found;
    int n;
    for (int i = 0; i < NS; i++) pos[i] = 0;
    found = 0;
    while (found >= 0) begin
      found = -1;
      for (int k = 1; k <= NS; k++) begin
        int i;
        i = (model_ptr + k) % NS;
        if (found < 0 && pos[i] < fq[i].size()) found = i;
      end
      if (found >= 0) begin
        n = fq[found].size() - pos[found];
        if (n > BL) n = BL;
        for (int j = 0; j < n; j++) begin
          beat_t b;
          b.data = tb_swap(fq[found][pos[found] + j]);
          b.tid  = IW'(found);
          b.last = (n == BL) && (j == BL - 1);
          exp_q.push_back(b);
        end
        pos[found] += n;
        model_ptr = found;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_tvalid"}, DW'(m_tvalid), DW'(0));
    chk({tag, "_grant"}, DW'(grant), DW'(0));
    chk({tag, "_busy"}, DW'(busy), DW'(0));
    chk({tag, "_rd_en"}, DW'(src_rd_en), DW'(0));
    chk({tag, "_tdata"}, m_tdata, DW'(0));
    chk({tag, "_tid"}, DW'(m_tid), DW'(0));
    chk({tag, "_tlast"}, DW'(m_tlast), DW'(0));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_ptr = NS - 1;
    exp_q.delete();
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain_in_time"}, DW'(n < 3000), DW'(1));
    if (n >= 3000) exp_q.delete();
    repeat (3) @(negedge clk);
    chk({tag, "_idle_busy"}, DW'(busy), DW'(0));
    chk({tag, "_idle_grant"}, DW'(grant), DW'(0));
  endtask

  // Source FIFO emulation: read data appears the cycle after the strobe.
  initial begin
    logic [NS-1:0] rd_snap;
    logic          hs_snap;
    logic          rst_snap;
    src_empty = '1;
    src_q     = '0;
    forever begin
      @(negedge clk);
      rd_snap  = src_rd_en;
      hs_snap  = m_tvalid && m_tready;
      rst_snap = rst;
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) begin
        if (rd_snap[i] === 1'b1) begin
          if (fq[i].size() > 0) begin
            src_q[i*DW +: DW] = fq[i].pop_front();
          end else begin
            checks++;
            errors++;
            $display("FAIL read_empty: got read of empty source %0d, expected none", i);
          end
        end
      end
      if (rst_snap) begin
        outstanding = 0;
      end else begin
        outstanding = outstanding + $countones(rd_snap) - int'(hs_snap);
        chk("rd_en_onehot", DW'($countones(rd_snap) <= 1), DW'(1));
        chk("outstanding_le2", DW'(outstanding <= 2), DW'(1));
      end
      for (int i = 0; i < NS; i++) src_empty[i] = (fq[i].size() == 0);
    end
  end

  // Ready driver: 0 = high, 1 = random, 2 = toggle, 3 = low.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        1:       m_tready = 1'($urandom_range(0, 1));
        2:       m_tready = ~m_tready;
        3:       m_tready = 1'b0;
        default: m_tready = 1'b1;
      endcase
    end
  end

  // Monitor: compares every accepted beat against the scoreboard and checks hold-while-stalled.
  initial begin
    logic          stall_prev;
    logic [DW-1:0] pd;
    logic [IW-1:0] pt;
    logic          pl;
    beat_t         e;
    stall_prev = 1'b0;
    pd = '0;
    pt = '0;
    pl = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("stall_valid", DW'(m_tvalid), DW'(1));
          chk("stall_data", m_tdata, pd);
          chk("stall_tid", DW'(m_tid), DW'(pt));
          chk("stall_last", DW'(m_tlast), DW'(pl));
        end
        if (m_tvalid && m_tready) begin
          hs_cnt++;
          hs_cyc.push_back(cyc);
          hs_tid.push_back(int'(m_tid));
          last_data = m_tdata;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got tid %0d data %0h, expected no beat", m_tid, m_tdata);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", m_tdata, e.data);
            chk("beat_tid", DW'(m_tid), DW'(e.tid));
            chk("beat_last", DW'(m_tlast), DW'(e.last));
          end
        end
        stall_prev = m_tvalid && !m_tready;
        pd = m_tdata;
        pt = m_tid;
        pl = m_tlast;
      end
    end
  end

  initial begin
    int            lat;
    int            base;
    int            n;
    logic [DW-1:0] w6;
    logic [DW-1:0] e6;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero("reset");

    // 1: one source with 20 words: full burst, 1 idle cycle, short burst.
    hs_cyc.delete();
    load_src(0, 20);
    model_build();
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    chk("t1_grant", DW'(grant), DW'(4'b0001));
    chk("t1_busy", DW'(busy), DW'(1));
    lat = 1;
    while (!m_tvalid && lat < 20) begin
      @(posedge clk);
      #2;
      lat++;
    end
    chk("t1_latency", DW'(lat), DW'(3));
    wait_drain("t1");
    chk("t1_beats", DW'(hs_cyc.size()), DW'(20));
    if (hs_cyc.size() == 20) begin
      chk("t1_gap_in_burst", DW'(hs_cyc[1] - hs_cyc[0]), DW'(1));
      chk("t1_gap_regrant", DW'(hs_cyc[16] - hs_cyc[15]), DW'(2));
    end

    // 2: all sources full bursts, round-robin 0..3 after reset.
    do_reset();
    @(negedge clk);
    hs_tid.delete();
    for (int s = 0; s < NS; s++) load_src(s, 16);
    model_build();
    wait_drain("t2");
    chk("t2_beats", DW'(hs_tid.size()), DW'(64));

    // 3: short burst from src1 then full burst from src2.
    do_reset();
    @(negedge clk);
    hs_tid.delete();
    load_src(1, 3);
    load_src(2, 16);
    model_build();
    wait_drain("t3");
    chk("t3_beats", DW'(hs_tid.size()), DW'(19));

    // 4: toggling ready then a long stall.
    @(negedge clk);
    base = hs_cnt;
    load_src(0, 20);
    load_src(3, 10);
    model_build();
    rmode = 2;
    repeat (30) @(posedge clk);
    rmode = 3;
    repeat (10) @(posedge clk);
    rmode = 0;
    wait_drain("t4");
    chk("t4_beats", DW'(hs_cnt - base), DW'(30));

    // 5: reset in the middle of a burst.
    do_reset();
    @(negedge clk);
    load_src(0, 20);
    load_src(1, 5);
    model_build();
    base = hs_cnt;
    n = 0;
    while (hs_cnt < base + 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reach_beat5", DW'(n < 200), DW'(1));
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero("t5_after_rst");
    exp_q.delete();
    model_ptr = NS - 1;
    hs_tid.delete();
    model_build();
    wait_drain("t5");
    chk("t5_first_src", DW'(hs_tid.size() > 0 ? hs_tid[0] : -1), DW'(0));

    // 6: lane ordering of a known word.
    @(negedge clk);
    w6 = 128'h33333333_22222222_11111111_00000000;
`ifdef FIFO_ARB_WORD_SWAP_EN
    e6 = 128'h00000000_11111111_22222222_33333333;
`else
    e6 = 128'h33333333_22222222_11111111_00000000;
`endif
    fq[0].push_back(w6);
    model_build();
    wait_drain("t6");
    chk("t6_word_order", last_data, e6);

    // 7: random fills with random backpressure.
    rmode = 1;
    for (int it = 0; it < 6; it++) begin
      @(negedge clk);
      for (int s = 0; s < NS; s++) load_src(s, $urandom_range(0, 40));
      model_build();
      wait_drain("t7");
    end
    rmode = 0;
    repeat (5) @(negedge clk);
    chk("final_queue_empty", DW'(exp_q.size()), DW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
